// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL lock sequencer.
// State encoding plus width functions used by the sequencer ports.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_WAIT_LOCK,
    S_STABLE,
    S_LOCKED,
    S_STANDBY,
    S_FAIL
  } pll_seq_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Counter only ever holds values up to max-1.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = max3(a, b, c);
    return (m > 1) ? $clog2(m) : 1;
  endfunction

  function automatic int rc_w(input int r);
    return (r > 0) ? $clog2(r + 1) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Two-flop synchroniser for asynchronous single-bit PLL status pins.
// Both flops clear to 0 on synchronous reset.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL_CORE control sequencer: reset pulse, lock qualification,
// timeout retries, standby and loss-of-lock handling.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RESET_CYCLES = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 64,
  parameter int MAX_RETRIES  = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          standby_req,
  input  logic                          pll_lock,
  output logic                          pll_reset,
  output logic                          pll_stdby,
  output logic                          locked,
  output logic                          lock_lost,
  output logic                          lock_fail,
  output logic [rc_w(MAX_RETRIES)-1:0]  retry_count
);

  localparam int CW = cnt_w(RESET_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RW = rc_w(MAX_RETRIES);

  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [RW-1:0] RTY_MAX  = RW'(MAX_RETRIES);

  pll_seq_state_t state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  retry_q, retry_d;
  logic           lost_d;
  logic           lock_s;

  logic pll_reset_q, pll_stdby_q, locked_q, lost_q, fail_q;

  pll_lock_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (pll_lock),
    .sync_o  (lock_s)
  );

  // Next state, shared counter and retry bookkeeping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    lost_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (enable) state_d = S_RESET;
      end
      S_RESET: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
        else cnt_d = cnt_q + 1'b1;
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RTY_MAX) begin
            state_d = S_FAIL;
          end else begin
            retry_d = retry_q + 1'b1;
            state_d = S_RESET;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STABLE: begin
        if (!lock_s) state_d = S_WAIT_LOCK;
        else if (cnt_q == STB_LAST) state_d = S_LOCKED;
        else cnt_d = cnt_q + 1'b1;
      end
      S_LOCKED: begin
        if (!lock_s) begin
          state_d = S_RESET;
          retry_d = '0;
          lost_d  = 1'b1;
        end else if (standby_req) begin
          state_d = S_STANDBY;
        end
      end
      S_STANDBY: begin
        if (!standby_req) state_d = S_WAIT_LOCK;
      end
      S_FAIL: begin
        state_d = S_FAIL;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (!enable) begin
      state_d = S_IDLE;
      lost_d  = 1'b0;
    end
    if (state_d == S_IDLE) retry_d = '0;
    if (state_d != state_q) cnt_d = '0;
  end

  // State, counter and Moore outputs decoded from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_reset_q <= 1'b1;
      pll_stdby_q <= 1'b0;
      locked_q    <= 1'b0;
      lost_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_reset_q <= state_d inside {S_IDLE, S_RESET, S_FAIL};
      pll_stdby_q <= (state_d == S_STANDBY);
      locked_q    <= (state_d == S_LOCKED);
      lost_q      <= lost_d;
      fail_q      <= (state_d == S_FAIL);
    end
  end

  assign pll_reset   = pll_reset_q;
  assign pll_stdby   = pll_stdby_q;
  assign locked      = locked_q;
  assign lock_lost   = lost_q;
  assign lock_fail   = fail_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Scoreboard bench for pll_lock_sequencer.
// Expected output vectors are queued per cycle and checked on negedge.
module tb_pll_lock_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       standby_req;
  logic       pll_lock;
  logic       pll_reset;
  logic       pll_stdby;
  logic       locked;
  logic       lock_lost;
  logic       lock_fail;
  logic [1:0] retry_count;

  int cyc = 0;
  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t sb[$];

  pll_lock_sequencer #(
    .RESET_CYCLES (4),
    .LOCK_TIMEOUT (20),
    .LOCK_STABLE  (8),
    .MAX_RETRIES  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .standby_req (standby_req),
    .pll_lock    (pll_lock),
    .pll_reset   (pll_reset),
    .pll_stdby   (pll_stdby),
    .locked      (locked),
    .lock_lost   (lock_lost),
    .lock_fail   (lock_fail),
    .retry_count (retry_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int c, input string n, input logic [6:0] v);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.v    = v;
    sb.push_back(e);
  endtask

  // Vector: {pll_reset, pll_stdby, locked, lock_lost, lock_fail, retry[1:0]}
  always @(negedge clk) begin
    logic [6:0] got;
    exp_t e;
    got = {pll_reset, pll_stdby, locked, lock_lost, lock_fail, retry_count};
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_chk++;
      if (e.cyc != cyc)
        $display("FAIL %s: check missed at cycle %0d (due %0d)",
                 e.name, cyc, e.cyc);
      else if (got !== e.v)
        $display("FAIL %s: cycle %0d got %b expected %b",
                 e.name, cyc, got, e.v);
      else
        n_pass++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst = 1'b1;
    enable = 1'b0;
    standby_req = 1'b0;
    pll_lock = 1'b0;
    step(3);
    push(cyc, "reset_vals", 7'b1000000);
    rst = 1'b0;
    step(2);

    // Nominal lock
    enable = 1'b1;
    c = cyc;
    push(c + 4, "nom_rst_hi", 7'b1000000);
    push(c + 5, "nom_rst_lo", 7'b0000000);
    step(10);
    pll_lock = 1'b1;
    c = cyc;
    push(c + 10, "nom_pre_lock", 7'b0000000);
    push(c + 11, "nom_locked", 7'b0010000);
    step(12);

    // Loss of lock
    pll_lock = 1'b0;
    c = cyc;
    push(c + 2, "lol_still_locked", 7'b0010000);
    push(c + 3, "lol_pulse", 7'b1001000);
    push(c + 4, "lol_pulse_end", 7'b1000000);
    push(c + 6, "lol_rst_hi", 7'b1000000);
    push(c + 7, "lol_rst_lo", 7'b0000000);
    step(9);

    // Glitchy lock
    pll_lock = 1'b1;
    c = cyc;
    push(c + 7, "gl_no_lock", 7'b0000000);
    step(5);
    pll_lock = 1'b0;
    step(2);
    pll_lock = 1'b1;
    c = cyc;
    push(c + 10, "gl_pre_lock", 7'b0000000);
    push(c + 11, "gl_locked", 7'b0010000);
    step(12);

    // Standby entry and exit
    standby_req = 1'b1;
    c = cyc;
    push(c, "sb_locked", 7'b0010000);
    push(c + 1, "sb_enter", 7'b0100000);
    step(10);
    pll_lock = 1'b0;
    push(cyc + 4, "sb_hold", 7'b0100000);
    step(5);
    standby_req = 1'b0;
    push(cyc + 1, "sb_exit", 7'b0000000);
    step(2);
    pll_lock = 1'b1;
    c = cyc;
    push(c + 10, "sb_pre_relock", 7'b0000000);
    push(c + 11, "sb_relocked", 7'b0010000);
    step(12);

    // Timeout, retries, fail
    enable = 1'b0;
    pll_lock = 1'b0;
    push(cyc + 1, "dis_idle", 7'b1000000);
    step(2);
    enable = 1'b1;
    c = cyc;
    push(c + 4, "to_rst0_hi", 7'b1000000);
    push(c + 5, "to_wait0", 7'b0000000);
    push(c + 24, "to_wait0_end", 7'b0000000);
    push(c + 25, "to_retry1", 7'b1000001);
    push(c + 28, "to_rst1_hi", 7'b1000001);
    push(c + 29, "to_wait1", 7'b0000001);
    push(c + 48, "to_wait1_end", 7'b0000001);
    push(c + 49, "to_retry2", 7'b1000010);
    push(c + 53, "to_wait2", 7'b0000010);
    push(c + 72, "to_wait2_end", 7'b0000010);
    push(c + 73, "to_fail", 7'b1000110);
    push(c + 80, "to_fail_hold", 7'b1000110);
    step(81);
    enable = 1'b0;
    push(cyc + 1, "fail_clear", 7'b1000000);
    step(3);

    // Mid-operation aborts
    pll_lock = 1'b1;
    enable = 1'b1;
    c = cyc;
    push(c + 5, "ab_wait", 7'b0000000);
    push(c + 8, "ab_stable", 7'b0000000);
    step(8);
    rst = 1'b1;
    push(cyc + 1, "ab_rst", 7'b1000000);
    step(1);
    rst = 1'b0;
    push(cyc + 1, "ab_reset_state", 7'b1000000);
    step(1);
    enable = 1'b0;
    push(cyc + 1, "ab_idle", 7'b1000000);
    push(cyc + 3, "ab_idle_hold", 7'b1000000);
    step(3);
    enable = 1'b1;
    c = cyc;
    push(c + 4, "ab_re_rst_hi", 7'b1000000);
    push(c + 5, "ab_re_rst_lo", 7'b0000000);
    step(7);

    step(3);
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never checked (due cycle %0d)", e.name, e.cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
